alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Clocked front-end controller for the combinational N-bit ALU (mode m, select s, operands a/b, outputs f/v/c).
- Loads operands from a shared data bus and latches the opcode on start.
- Holds ALU inputs stable for a settle window, then registers f/v/c and pulses done.
- Optional chain mode writes the result back into operand A, so multi-step operations run without reloading.

Parameters:
N, 8, operand/result width; must match the ALU.
SETTLE, 2, cycles ALU inputs are held before capture; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
din  input  N  operand load bus
ld_a  input  1  load din into operand A register
ld_b  input  1  load din into operand B register
op_m  input  1  ALU mode, sampled on accepted start
op_s  input  2  ALU select, sampled on accepted start
chain  input  1  sampled on accepted start; 1 = write result back into A at capture
start  input  1  request one operation
alu_m  output  1  to ALU m
alu_s  output  2  to ALU s
alu_a  output  N  to ALU a (operand A register)
alu_b  output  N  to ALU b (operand B register)
alu_f  input  N  from ALU f
alu_v  input  1  from ALU v
alu_c  input  1  from ALU c
busy  output  1  settle window in progress
done  output  1  one-cycle pulse; result registers valid
result  output  N  captured f
v_out  output  1  captured v
c_out  output  1  captured c
err  output  1  sticky: start arrived while busy

Behaviour:
- Reset, rst_n low at a rising edge: all registers cleared.
  - alu_m=0, alu_s=0, alu_a=0, alu_b=0, result=0, v_out=0, c_out=0, busy=0, done=0, err=0.
  - FSM goes to IDLE and the settle counter goes to 0.
  - Reset has priority over every other input, including mid-operation. An aborted operation produces no done and no capture.
- FSM states:
  - IDLE: busy=0.
  - SETTLE: busy=1.
  - CAPTURE: a single edge action, not a dwell state.
  - done is registered and is high only in the first cycle after capture.
- Operand loads:
  - Accepted only when busy=0, including the done cycle.
  - ld_a and ld_b together load din into both registers.
  - Loads while busy=1 are ignored; operands stay frozen.
- start accepted (busy=0 at the sampling edge):
  - Latch op_m→alu_m, op_s→alu_s, chain→chain_q.
  - Clear err.
  - Load counter with SETTLE-1, enter SETTLE.
  - A load in the same cycle as an accepted start takes effect, so the ALU sees the new operand.
- Timing: start sampled at edge 0.
  - busy=1 during cycles 0..SETTLE-1.
  - Counter decrements each edge while in SETTLE.
  - At edge SETTLE: result<=alu_f, v_out<=alu_v, c_out<=alu_c, done=1 for cycle SETTLE, busy=0, state=IDLE.
  - If chain_q=1, the same edge writes alu_a<=alu_f. This wins over a simultaneous ld_a, which is ignored because busy was 1.
  - start-to-done latency is exactly SETTLE cycles.
  - Back-to-back: start high during the done cycle is accepted, giving one operation every SETTLE+1 cycles at best.
- start while busy=1: ignored, err<=1. err stays set until reset or the next accepted start.
- Result registers and alu_m/alu_s hold their values until the next capture or reset.
- Arithmetic: none inside this block. Width is N throughout; no truncation or extension.

Test Plan:
1. Reset/defaults: hold rst_n=0 for 3 cycles with start=1 and ld_a=1, din=8'hFF → every output is 0 and done never pulses.
2. Basic op, SETTLE=2: ld_a with din=8'h3C, then ld_b with din=8'h05, then start with op_m=0, op_s=2'b01; bench ALU stub drives f=8'h41, v=0, c=1 → busy high exactly 2 cycles, done high for 1 cycle 2 cycles after the start edge, result=8'h41, c_out=1.
3. Frozen operands: during busy, pulse ld_a with din=8'hAA → alu_a stays 8'h3C, and is only loaded after a subsequent ld_a when idle.
4. Chain: A=8'h01, chain=1, stub returns f=alu_a+1; issue start in each done cycle, 3 times → result sequence 02, 03, 04; alu_a=8'h04; ops spaced every 3 cycles.
5. Error: start again in the busy cycle after an accepted start → err=1, op completes normally with a single done pulse; next accepted start clears err.
6. Reset mid-operation: rst_n=0 during the first busy cycle → busy=0 next cycle, no done, result unchanged at 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for a combinational ALU: loads operands, holds the
// ALU inputs for a settle window, then captures f/v/c and pulses done.
module alu_op_sequencer #(
  parameter int N      = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         ld_a,
  input  logic         ld_b,
  input  logic         op_m,
  input  logic [1:0]   op_s,
  input  logic         chain,
  input  logic         start,
  output logic         alu_m,
  output logic [1:0]   alu_s,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_f,
  input  logic         alu_v,
  input  logic         alu_c,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         v_out,
  output logic         c_out,
  output logic         err
);

  typedef enum logic {
    ST_IDLE,
    ST_SETTLE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       chain_q;
  logic       accept;
  logic       capture;

  assign busy = (state_q == ST_SETTLE);

  // State and settle counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: accept start when idle, count down, capture on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
          cnt_d   = CNT_INIT;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand, opcode, result and error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_m   <= 1'b0;
      alu_s   <= 2'd0;
      alu_a   <= '0;
      alu_b   <= '0;
      chain_q <= 1'b0;
      result  <= '0;
      v_out   <= 1'b0;
      c_out   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (!busy) begin
        if (ld_a) alu_a <= din;
        if (ld_b) alu_b <= din;
      end
      if (accept) begin
        alu_m   <= op_m;
        alu_s   <= op_s;
        chain_q <= chain;
        err     <= 1'b0;
      end else if (busy && start) begin
        err <= 1'b1;
      end
      if (capture) begin
        result <= alu_f;
        v_out  <= alu_v;
        c_out  <= alu_c;
        if (chain_q) alu_a <= alu_f;
      end
      done <= capture;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a functional ALU stub
// and a timestamp-based reference model of the sequencing rules.
module tb_alu_op_sequencer;

  localparam int N  = 8;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] din = '0;
  logic         ld_a = 1'b0;
  logic         ld_b = 1'b0;
  logic         op_m = 1'b0;
  logic [1:0]   op_s = 2'd0;
  logic         chain = 1'b0;
  logic         start = 1'b0;
  logic         alu_m;
  logic [1:0]   alu_s;
  logic [N-1:0] alu_a, alu_b, alu_f;
  logic         alu_v, alu_c;
  logic         busy, done, v_out, c_out, err;
  logic [N-1:0] result;

  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.N(N), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .din(din),
    .ld_a(ld_a), .ld_b(ld_b), .op_m(op_m),
    .op_s(op_s), .chain(chain), .start(start),
    .alu_m(alu_m), .alu_s(alu_s),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_v(alu_v), .alu_c(alu_c),
    .busy(busy), .done(done), .result(result),
    .v_out(v_out), .c_out(c_out), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [N+1:0] stub(
    input logic m, input logic [1:0] s,
    input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] f;
    case (s)
      2'd0: f = a + 8'd1;
      2'd1: f = a + b;
      2'd2: f = a ^ b;
      default: f = a & b;
    endcase
    if (m) f = ~f;
    return {f[N-1] ^ a[N-1], |(a & b), f};
  endfunction

  always_comb {alu_v, alu_c, alu_f} = stub(alu_m, alu_s, alu_a, alu_b);

  // reference model: an op started at edge e completes at edge e+ST
  logic [N-1:0] ma, mb, mres;
  logic [1:0]   ms;
  logic         mm, mch, mv, mc, merr, mdone;
  int           due = -1;
  int           cyc = 0;

  function automatic void model_edge();
    logic [N+1:0] r;
    if (!rst_n) begin
      ma = '0; mb = '0; mres = '0; ms = '0;
      mm = 0; mch = 0; mv = 0; mc = 0;
      merr = 0; mdone = 0; due = -1;
    end else begin
      mdone = 0;
      if (due >= 0) begin
        if (start) merr = 1;
        if (cyc == due) begin
          r = stub(mm, ms, ma, mb);
          {mv, mc, mres} = r;
          if (mch) ma = r[N-1:0];
          mdone = 1;
          due = -1;
        end
      end else begin
        if (ld_a) ma = din;
        if (ld_b) mb = din;
        if (start) begin
          mm = op_m; ms = op_s; mch = chain;
          merr = 0; due = cyc + ST;
        end
      end
    end
    cyc++;
  endfunction

  function automatic logic [40:0] exp_vec();
    return {mm, ms, ma, mb, due >= 0, mdone,
            mres, mv, mc, merr};
  endfunction

  function automatic logic [40:0] dut_vec();
    return {alu_m, alu_s, alu_a, alu_b, busy, done,
            result, v_out, c_out, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    ld_a = 0; ld_b = 0; start = 0; chain = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 1; ld_a = 1; din = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (dut_vec() !== '0) begin
        bad++;
        $display("FAIL reset_outputs got=%h want=0", dut_vec());
      end
    end
    idle_in();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    ld_a = 1; din = 8'h3C; tick();
    ld_a = 0; ld_b = 1; din = 8'h05; tick();
    ld_b = 0; start = 1; op_m = 0; op_s = 2'b01; tick();
    start = 0;
    for (int i = 0; i < ST; i++) begin
      total++;
      if ({busy, done} !== 2'b10) begin
        bad++;
        $display("FAIL basic_busy%0d got=%b want=10", i, {busy, done});
      end
      tick();
    end
    total++;
    if ({busy, done, result, v_out, c_out} !== {2'b01, 8'h41, 2'b01}) begin
      bad++;
      $display("FAIL basic_done got=%b%b %h %b%b want=01 41 01",
               busy, done, result, v_out, c_out);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse got=%b want=0", done);
    end
  endtask

  task automatic test_frozen();
    start = 1; op_s = 2'b01; tick();
    start = 0; ld_a = 1; din = 8'hAA; tick();
    ld_a = 0;
    total++;
    if (alu_a !== 8'h3C) begin
      bad++;
      $display("FAIL frozen_busy got=%h want=3c", alu_a);
    end
    tick();
    total++;
    if ({done, alu_a} !== {1'b1, 8'h3C}) begin
      bad++;
      $display("FAIL frozen_done got=%b %h want=1 3c", done, alu_a);
    end
    ld_a = 1; din = 8'hAA; tick();
    ld_a = 0;
    total++;
    if (alu_a !== 8'hAA) begin
      bad++;
      $display("FAIL frozen_reload got=%h want=aa", alu_a);
    end
  endtask

  task automatic test_chain();
    int last;
    ld_a = 1; din = 8'h01; tick();
    ld_a = 0; start = 1; chain = 1; op_m = 0; op_s = 2'b00; tick();
    start = 0; chain = 0;
    last = -1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ST; i++) tick();
      total++;
      if ({done, result} !== {1'b1, 8'(k + 2)}) begin
        bad++;
        $display("FAIL chain_res%0d got=%b %h want=1 %h",
                 k, done, result, 8'(k + 2));
      end
      if (last >= 0) begin
        total++;
        if (cyc - last !== ST + 1) begin
          bad++;
          $display("FAIL chain_gap got=%0d want=%0d", cyc - last, ST + 1);
        end
      end
      last = cyc;
      if (k < 2) begin
        start = 1; chain = 1; tick();
        start = 0; chain = 0;
      end
    end
    total++;
    if (alu_a !== 8'h04) begin
      bad++;
      $display("FAIL chain_a got=%h want=04", alu_a);
    end
  endtask

  task automatic test_error();
    int dones;
    start = 1; op_s = 2'b10; tick();
    tick();
    start = 0;
    total++;
    if ({busy, err} !== 2'b11) begin
      bad++;
      $display("FAIL err_set got=%b want=11", {busy, err});
    end
    dones = 0;
    for (int i = 0; i < ST + 2; i++) begin
      tick();
      if (done) dones++;
    end
    total++;
    if ({dones, err} !== {32'd1, 1'b1}) begin
      bad++;
      $display("FAIL err_single got=%0d %b want=1 1", dones, err);
    end
    start = 1; tick();
    start = 0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b want=0", err);
    end
    for (int i = 0; i < ST + 1; i++) tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    rst_n = 0; tick();
    rst_n = 1;
    ld_a = 1; ld_b = 1; din = 8'h77; start = 1; op_s = 2'b01; tick();
    idle_in();
    rst_n = 0; tick();
    rst_n = 1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_busy got=%b want=0", busy);
    end
    dones = 0;
    for (int i = 0; i < ST + 2; i++) begin
      tick();
      if (done) dones++;
    end
    total++;
    if ({dones, result} !== {32'd0, 8'h00}) begin
      bad++;
      $display("FAIL rstmid_nodone got=%0d %h want=0 00", dones, result);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      start = ($urandom_range(0, 2) == 0);
      ld_a  = ($urandom_range(0, 2) == 0);
      ld_b  = ($urandom_range(0, 2) == 0);
      din   = 8'($urandom);
      op_m  = 1'($urandom);
      op_s  = 2'($urandom);
      chain = 1'($urandom);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rand_cyc%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    rst_n = 1;
    idle_in();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frozen();
    test_chain();
    test_error();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
